// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver:
// parity mode codes, receiver state encoding, default error character
// and the frame-length helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int DEFAULT_ERR_CHAR = 'h3F;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Clock cycles from start-detect to the completion strobe for one frame
  function automatic int frame_clks(input int data_w, input int par_mode, input int cpb);
    return (2 + data_w + ((par_mode != PAR_NONE) ? 1 : 0)) * cpb;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: cnt runs 0..CLKS_PER_BIT-1 and wraps; restart holds it
// at 0 so the cycle after a release is cnt = 1 (the release cycle is cnt = 0).
// mid_bit marks the sample point, end_bit the last cycle of the bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 14
) (
  input  logic clk_3125,
  input  logic rst,
  input  logic restart,
  output logic mid_bit,
  output logic end_bit
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_reg;

  assign mid_bit = (cnt_reg == CNT_W'(CLKS_PER_BIT / 2));
  assign end_bit = (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

  // Free-running bit counter, cleared by reset, restart or end of bit
  always_ff @(posedge clk_3125) begin
    if (rst || restart || end_bit) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: start, DATA_W data bits, optional parity, stop.
// Rejects short start glitches, flags parity and framing errors, and stays
// disarmed after a framing error until the line has returned high.
// Optional build macro UART_RX_SYNC_EN adds a 2-flop input synchroniser.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 14,
  parameter int DATA_W       = 8,
  parameter int PARITY_MODE  = PAR_EVEN,
  parameter int MSB_FIRST    = 1,
  parameter int ERR_CHAR     = DEFAULT_ERR_CHAR
) (
  input  logic              clk_3125,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_msg,
  output logic              rx_parity,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_complete
);

  localparam int                BIDX_W  = $clog2(DATA_W);
  localparam bit                HAS_PAR = (PARITY_MODE != PAR_NONE);
  localparam bit                ODD_PAR = (PARITY_MODE == PAR_ODD);
  localparam logic [DATA_W-1:0] ERR_W   = ERR_CHAR[DATA_W-1:0];

  logic rx_s;      // line sample used by the receiver
  logic rx_valid;  // rx_s reflects the real pin (not a reset value)

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_reg;
  logic [1:0] fill_reg;

  // Two-flop synchroniser; fill_reg tracks when its reset value has flushed out
  always_ff @(posedge clk_3125) begin
    if (rst) begin
      sync_reg <= 2'b11;
      fill_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], rx};
      fill_reg <= {fill_reg[0], 1'b1};
    end
  end

  assign rx_s     = sync_reg[1];
  assign rx_valid = fill_reg[1];
`else
  assign rx_s     = rx;
  assign rx_valid = 1'b1;
`endif

  rx_state_t          state_reg, state_next;
  logic               restart;
  logic               mid_bit, end_bit;
  logic               armed_reg;
  logic [BIDX_W-1:0]  bit_idx_reg;
  logic [DATA_W-1:0]  data_reg;
  logic               par_reg;
  logic               stop_reg;
  logic [DATA_W-1:0]  msg_reg;
  logic               parity_out_reg;
  logic               perr_reg;
  logic               ferr_reg;
  logic               complete_reg;
  logic               par_err;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk_3125(clk_3125),
    .rst     (rst),
    .restart (restart),
    .mid_bit (mid_bit),
    .end_bit (end_bit)
  );

  // Even mode: XOR of data and parity must be 0; odd mode: must be 1
  assign par_err = HAS_PAR && (((^data_reg) ^ par_reg) != ODD_PAR);

  // State register
  always_ff @(posedge clk_3125) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and bit-timer restart control
  always_comb begin
    state_next = state_reg;
    restart    = 1'b0;
    case (state_reg)
      IDLE: begin
        restart = 1'b1;
        if (armed_reg && !rx_s) begin
          state_next = START;
          restart    = 1'b0;   // detect cycle is cnt = 0
        end
      end
      START: begin
        if (mid_bit && rx_s) begin
          state_next = IDLE;   // glitch: line back high at mid-bit
          restart    = 1'b1;
        end else if (end_bit) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (end_bit && (bit_idx_reg == BIDX_W'(DATA_W - 1))) begin
          state_next = HAS_PAR ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (end_bit) state_next = STOP;
      end
      STOP: begin
        if (end_bit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: arming, bit capture and output registers
  always_ff @(posedge clk_3125) begin
    if (rst) begin
      armed_reg      <= 1'b0;
      bit_idx_reg    <= '0;
      data_reg       <= '0;
      par_reg        <= 1'b0;
      stop_reg       <= 1'b1;
      msg_reg        <= '0;
      parity_out_reg <= 1'b0;
      perr_reg       <= 1'b0;
      ferr_reg       <= 1'b0;
      complete_reg   <= 1'b0;
    end else begin
      complete_reg <= 1'b0;
      // A low stop bit disarms so a held-low break is not read as frames
      if (state_reg == STOP && end_bit && !stop_reg) begin
        armed_reg <= 1'b0;
      end else if (rx_s && rx_valid) begin
        armed_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: bit_idx_reg <= '0;
        DATA: begin
          if (mid_bit) begin
            if (MSB_FIRST != 0) data_reg <= {data_reg[DATA_W-2:0], rx_s};
            else                data_reg <= {rx_s, data_reg[DATA_W-1:1]};
          end
          if (end_bit) bit_idx_reg <= bit_idx_reg + BIDX_W'(1);
        end
        PARITY: begin
          if (mid_bit) par_reg <= rx_s;
        end
        STOP: begin
          if (mid_bit) stop_reg <= rx_s;
          if (end_bit) begin
            msg_reg        <= par_err ? ERR_W : data_reg;
            parity_out_reg <= HAS_PAR ? par_reg : 1'b0;
            perr_reg       <= par_err;
            ferr_reg       <= !stop_reg;
            complete_reg   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_msg        = msg_reg;
  assign rx_parity     = parity_out_reg;
  assign rx_parity_err = perr_reg;
  assign rx_frame_err  = ferr_reg;
  assign rx_complete   = complete_reg;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: DUT A uses the default configuration, DUT B uses
// DATA_W=7, odd parity, LSB first. Frame vectors come from a table; the
// glitch, break and mid-frame reset cases are hand-written sequences.
module tb_uart_rx_cfg;

  localparam int CPB = 14;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int LAT_A = 154 + SYNC_LAT;
  localparam int LAT_B = 140 + SYNC_LAT;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       rx_a, rx_b;
  logic [7:0] rx_msg_a;
  logic [6:0] rx_msg_b;
  logic       par_a, perr_a, ferr_a, cpl_a;
  logic       par_b, perr_b, ferr_b, cpl_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #160 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg dut_a (
    .clk_3125(clk), .rst(rst_a), .rx(rx_a), .rx_msg(rx_msg_a), .rx_parity(par_a),
    .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_complete(cpl_a)
  );

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_W(7), .PARITY_MODE(2), .MSB_FIRST(0)) dut_b (
    .clk_3125(clk), .rst(rst_b), .rx(rx_b), .rx_msg(rx_msg_b), .rx_parity(par_b),
    .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .rx_complete(cpl_b)
  );

  typedef struct {
    int         cyc;
    logic [7:0] msg;
    logic       par;
    logic       perr;
    logic       ferr;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];

  // Strobe monitors: one line per received character
  always @(negedge clk) begin
    ev_t e;
    if (cpl_a === 1'b1) begin
      e = '{cyc, rx_msg_a, par_a, perr_a, ferr_a};
      qa.push_back(e);
      $display("A rx cycle %0d msg=%02h par=%b perr=%b ferr=%b", cyc, rx_msg_a, par_a, perr_a, ferr_a);
    end
    if (cpl_b === 1'b1) begin
      e = '{cyc, {1'b0, rx_msg_b}, par_b, perr_b, ferr_b};
      qb.push_back(e);
      $display("B rx cycle %0d msg=%02h par=%b perr=%b ferr=%b", cyc, rx_msg_b, par_b, perr_b, ferr_b);
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    int         gap;
    logic [7:0] exp_msg;
    logic       exp_par;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  // Drive line bits (index 0 first) for CPB cycles each; stop early at abort_at
  task automatic send_frame(input bit sel, input logic [15:0] line, input int nbits,
                            input int abort_at, output int start_cyc);
    start_cyc = cyc;
    for (int c = 0; c < nbits * CPB && c != abort_at; c++) begin
      set_rx(sel, line[c / CPB]);
      @(negedge clk);
    end
  endtask

  // Default config: start, data MSB first, parity, stop
  function automatic logic [15:0] line_a(input logic [7:0] d, input logic p, input logic s);
    logic [15:0] l;
    l = '1;
    l[0] = 1'b0;
    for (int k = 0; k < 8; k++) l[1 + k] = d[7 - k];
    l[9]  = p;
    l[10] = s;
    return l;
  endfunction

  // Config B: start, 7 data bits LSB first, parity, stop
  function automatic logic [15:0] line_b(input logic [6:0] d, input logic p, input logic s);
    logic [15:0] l;
    l = '1;
    l[0] = 1'b0;
    for (int k = 0; k < 7; k++) l[1 + k] = d[k];
    l[8] = p;
    l[9] = s;
    return l;
  endfunction

  vec_t vt[13];
  int   st[13];
  int   s0;

  initial begin
    // data, parity bit on line, stop bit, idle gap, expected msg/par/perr/ferr
    vt[0]  = '{8'h41, 1'b0, 1'b1, 3, 8'h41, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{8'h41, 1'b1, 1'b1, 3, 8'h3F, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{8'h48, 1'b0, 1'b1, 3, 8'h48, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{8'h45, 1'b1, 1'b1, 0, 8'h45, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{8'h4C, 1'b1, 1'b1, 0, 8'h4C, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{8'h4C, 1'b1, 1'b1, 0, 8'h4C, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{8'h4F, 1'b1, 1'b1, 0, 8'h4F, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{8'h57, 1'b1, 1'b1, 0, 8'h57, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{8'h4F, 1'b1, 1'b1, 0, 8'h4F, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{8'h52, 1'b1, 1'b1, 0, 8'h52, 1'b1, 1'b0, 1'b0};
    vt[10] = '{8'h4C, 1'b1, 1'b1, 0, 8'h4C, 1'b1, 1'b0, 1'b0};
    vt[11] = '{8'h44, 1'b0, 1'b1, 0, 8'h44, 1'b0, 1'b0, 1'b0};
    vt[12] = '{8'h5A, 1'b0, 1'b0, 3, 8'h5A, 1'b0, 1'b0, 1'b1};

    rst_a = 1'b1; rst_b = 1'b1;
    rx_a  = 1'b0; rx_b  = 1'b1;
    repeat (4) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    chk("reset rx_msg", 32'(rx_msg_a), 32'h0);
    chk("reset rx_parity", 32'(par_a), 32'h0);
    chk("reset parity_err", 32'(perr_a), 32'h0);
    chk("reset frame_err", 32'(ferr_a), 32'h0);
    chk("reset rx_complete", 32'(cpl_a), 32'h0);

    // rx held low out of reset: nothing may be received
    repeat (50) @(negedge clk);
    chk("low after reset strobes", 32'(qa.size()), 32'd0);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);

    // Table-driven frames: good, parity error, HELLOWORLD back-to-back, framing error
    for (int i = 0; i < 13; i++) begin
      rx_a = 1'b1;
      repeat (vt[i].gap) @(negedge clk);
      send_frame(1'b0, line_a(vt[i].data, vt[i].par_bit, vt[i].stop_bit), 11, -1, st[i]);
    end
    // Break: line held low after the framing-error frame
    rx_a = 1'b0;
    repeat (500) @(negedge clk);
    chk("strobes after break", 32'(qa.size()), 32'd13);
    for (int i = 0; i < 13; i++) begin
      if (i < qa.size()) begin
        chk($sformatf("v%0d latency", i), 32'(qa[i].cyc - st[i]), 32'(LAT_A));
        chk($sformatf("v%0d rx_msg", i), 32'(qa[i].msg), 32'(vt[i].exp_msg));
        chk($sformatf("v%0d rx_parity", i), 32'(qa[i].par), 32'(vt[i].exp_par));
        chk($sformatf("v%0d parity_err", i), 32'(qa[i].perr), 32'(vt[i].exp_perr));
        chk($sformatf("v%0d frame_err", i), 32'(qa[i].ferr), 32'(vt[i].exp_ferr));
        if (i >= 3 && i <= 11)
          chk($sformatf("v%0d spacing", i), 32'(qa[i].cyc - qa[i-1].cyc), 32'd154);
      end else begin
        checks++;
        errors++;
        $display("FAIL v%0d strobe: got none expected one", i);
      end
    end

    // Line rises again: a new frame is accepted
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(1'b0, line_a(8'h41, 1'b0, 1'b1), 11, -1, s0);
    rx_a = 1'b1;
    repeat (170) @(negedge clk);
    chk("strobes after re-arm", 32'(qa.size()), 32'd14);
    if (qa.size() == 14) begin
      chk("re-arm latency", 32'(qa[13].cyc - s0), 32'(LAT_A));
      chk("re-arm rx_msg", 32'(qa[13].msg), 32'h41);
      chk("re-arm frame_err", 32'(qa[13].ferr), 32'h0);
    end

    // Start glitch: 5 low cycles must be ignored and outputs held
    rx_a = 1'b0;
    repeat (5) @(negedge clk);
    rx_a = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch strobes", 32'(qa.size()), 32'd14);
    chk("glitch rx_msg", 32'(rx_msg_a), 32'h41);
    chk("glitch rx_parity", 32'(par_a), 32'h0);
    chk("glitch parity_err", 32'(perr_a), 32'h0);
    chk("glitch frame_err", 32'(ferr_a), 32'h0);

    // Config B: 0x55, 7 bits LSB first, odd parity -> parity bit 1
    send_frame(1'b1, line_b(7'h55, 1'b1, 1'b1), 10, -1, s0);
    rx_b = 1'b1;
    repeat (160) @(negedge clk);
    chk("B strobes", 32'(qb.size()), 32'd1);
    if (qb.size() == 1) begin
      chk("B latency", 32'(qb[0].cyc - s0), 32'(LAT_B));
      chk("B rx_msg", 32'(qb[0].msg), 32'h55);
      chk("B rx_parity", 32'(qb[0].par), 32'h1);
      chk("B parity_err", 32'(qb[0].perr), 32'h0);
      chk("B frame_err", 32'(qb[0].ferr), 32'h0);
    end

    // Config B again, reset 60 cycles into the frame
    send_frame(1'b1, line_b(7'h55, 1'b1, 1'b1), 10, 60, s0);
    rst_b = 1'b1;
    rx_b  = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    repeat (200) @(negedge clk);
    chk("B reset strobes", 32'(qb.size()), 32'd1);
    chk("B reset rx_msg", 32'(rx_msg_b), 32'h0);
    chk("B reset rx_parity", 32'(par_b), 32'h0);
    chk("B reset parity_err", 32'(perr_b), 32'h0);
    chk("B reset frame_err", 32'(ferr_b), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver, the successor to the fixed 8-bit even-parity receiver in the colour-sensor telemetry path. It runs on the 3.125 MHz system clock and adds the following over the fixed receiver: configurable data width, bit order, parity mode and bit period; start-bit glitch rejection; framing-error detection; and break/idle re-arming. Decoded characters go to the downstream message/command logic with a one-cycle completion strobe.

## Interface
- CLKS_PER_BIT, 14: clock cycles per bit; range ≥4, even values preferred.
- DATA_W, 8: data bits per frame; range 5..9.
- PARITY_MODE, 1: 0 = none, 1 = even, 2 = odd.
- MSB_FIRST, 1: 1 = first data bit on the line is rx_msg[DATA_W-1]; 0 = LSB first.
- ERR_CHAR, 'h3F: substituted on rx_msg on parity error; truncated or zero-extended to DATA_W.

- clk_3125  in  1  system clock, 3.125 MHz; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  serial line; idle high.
- rx_msg  out  DATA_W  last received character, or ERR_CHAR.
- rx_parity  out  1  received parity bit; 0 when PARITY_MODE=0.
- rx_parity_err  out  1  last frame failed the parity check.
- rx_frame_err  out  1  last frame had a low stop bit.
- rx_complete  out  1  one-cycle strobe; all other outputs update in the same cycle.

## Operation
- Frame: start(0), DATA_W data bits, optional parity bit, stop(1). FRAME_CLKS = (2 + DATA_W + P) × CLKS_PER_BIT, where P = (PARITY_MODE != 0). Defaults give 154.
- In the text below, rx_s is the internal line sample (see Configuration).
- State machine states: IDLE, START, DATA, PARITY, STOP.
- A bit counter cnt runs 0..CLKS_PER_BIT-1. Sampling is at cnt == CLKS_PER_BIT/2.
- **IDLE**
  - The receiver is armed once rx_s has been seen high at least one cycle.
  - Armed and rx_s == 0: go to START. The detect cycle counts as cnt = 0.
- **START**
  - rx_s == 1 at the sample point: false start; return to IDLE, still armed. No outputs change.
  - Otherwise at cnt end: go to DATA.
- **DATA**
  - Shift in rx_s at each sample point.
  - After DATA_W bits: go to PARITY if P, otherwise STOP.
- **PARITY**
  - Latch the sample.
  - Error if the XOR of data and parity is 1 (even mode) or 0 (odd mode).
- **STOP**
  - Sample the stop bit; 0 means framing error.
  - At cnt end: go to IDLE and register all outputs.
- **Output selection and hold**
  - rx_msg = ERR_CHAR on a parity error; otherwise the data in the configured bit order.
  - A framing error keeps the received data on rx_msg and sets rx_frame_err.
  - Outputs hold until the next completed frame. The error flags are rewritten on every frame.
- **After a framing error**
  - The receiver is disarmed. rx must return high before a new start is accepted, so a break is not read as repeated frames.

## Timing
- **Reset values:** rx_msg = 0, rx_parity = 0, rx_parity_err = 0, rx_frame_err = 0, rx_complete = 0. State is IDLE, disarmed.
- **Reset mid-frame:** the state machine is in IDLE the next cycle. No rx_complete is issued and the partial data is discarded.
- **Latency:** rx_complete is high in the cycle FRAME_CLKS after the start-detect cycle, for exactly 1 cycle.
- **Back-to-back frames:** a start bit immediately following the stop bit is detected in the IDLE cycle coinciding with rx_complete. There are no gaps between frames and no lost frames.
- **rx held low out of reset:** no frame is received until rx has gone high.
- No ready/valid backpressure; a consumer must capture rx_msg on rx_complete.

## Configuration
- UART_RX_SYNC_EN defined:
  - rx passes through a 2-flop synchroniser, both flops reset to 1.
  - All latencies measured from the rx pin increase by 2 cycles.
- UART_RX_SYNC_EN undefined:
  - rx is used directly as rx_s.
  - rx must already be synchronous to clk_3125.

## Structure
- Package uart_pkg:
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - rx_state_t enum;
  - DEFAULT_ERR_CHAR;
  - frame_clks(data_w, par_mode, cpb) function.
- Sub-module uart_bit_timer:
  - cnt counter with restart input;
  - mid-bit (sample) and end-of-bit strobes;
  - parameterised by CLKS_PER_BIT.

## Test plan
- **Good frame:** defaults, send 0x41 MSB-first with parity 0 → rx_complete at start + 154 cycles; rx_msg = 0x41, rx_parity = 0, both error flags 0.
- **Parity error:** send 0x41 with parity 1 → rx_msg = 0x3F, rx_parity = 1, rx_parity_err = 1.
- **Glitch rejection:** rx low for 5 cycles, then high → no rx_complete, and outputs unchanged.
- **Back-to-back stream:** ten frames "HELLOWORLD" with no gap → ten strobes spaced exactly 154 cycles, all characters correct.
- **Framing error and break:** stop bit 0 → rx_frame_err = 1 and rx_msg = data; rx then held low 500 cycles → no further strobes until rx rises.
- **Non-default configuration plus reset:** DATA_W = 7, PARITY_MODE = 2, MSB_FIRST = 0, 0x55 → correct decode, rx_complete at start + 140. Repeat with rst asserted at cycle 60 → no strobe and all outputs 0.
